// File: rtl/adder_pkg.sv
// Shared definitions for the adder result sink: FSM state encoding and result widths.
package adder_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam int ADDER_W = 4;
    localparam int RES_W   = ADDER_W + 1;

endpackage

// File: rtl/adder_frame_cnt.sv
// Frame beat counter; tc flags that the next increment completes the frame.
module adder_frame_cnt #(
    parameter int W      = 3,
    parameter int TC_VAL = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == W'(TC_VAL - 1));

endmodule

// File: rtl/adder_sum_accum.sv
// Accumulates N_SAMPLES unsigned {c_out, sum} adder results and presents the frame total.
// Build option ADDER_ACC_SAT_EN: clamp the total at 2^ACC_W-1 instead of wrapping.
module adder_sum_accum
    import adder_pkg::*;
#(
    parameter int ACC_W     = 8,
    parameter int N_SAMPLES = 5,
    localparam int CNT_W    = $clog2(N_SAMPLES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDER_W-1:0] in_sum,
    input  logic               in_c_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_acc,
    output logic               out_overflow,
    output logic [CNT_W-1:0]   out_count
);

    // Returns {carry, next_acc}; carry marks that the true total left ACC_W bits.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc,
                                               input logic [RES_W-1:0] val);
        logic [ACC_W:0] s;
        s = {1'b0, acc} + (ACC_W + 1)'(val);
`ifdef ADDER_ACC_SAT_EN
        if (s[ACC_W]) begin
            s[ACC_W-1:0] = '1;
        end
`endif
        return s;
    endfunction

    state_t           state_q;
    state_t           state_d;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_tc;
    logic             accept;
    logic             xfer;
    logic [ACC_W:0]   acc_nxt;

    assign accept  = in_valid && (state_q == ACCUM);
    assign xfer    = out_ready && (state_q == DONE);
    assign acc_nxt = acc_add(acc_q, {in_c_out, in_sum});

    adder_frame_cnt #(
        .W      (CNT_W),
        .TC_VAL (N_SAMPLES)
    ) u_frame_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear || xfer),
        .inc   (accept),
        .count (cnt_q),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (accept && cnt_tc) state_d = DONE;
            DONE:    if (out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
        if (clear) begin
            state_d = ACCUM;
        end
    end

    // Overflow is sticky until the frame is transferred, cleared or reset.
    always_ff @(posedge clk) begin
        if (rst || clear || xfer) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            acc_q <= acc_nxt[ACC_W-1:0];
            ovf_q <= ovf_q || acc_nxt[ACC_W];
        end
    end

    assign in_ready     = (state_q == ACCUM);
    assign out_valid    = (state_q == DONE);
    assign out_acc      = acc_q;
    assign out_overflow = ovf_q;
    assign out_count    = cnt_q;

endmodule

// File: tb/tb_adder_sum_accum.sv
// Scoreboard bench for adder_sum_accum: default instance plus a 10-sample instance for overflow.
module tb_adder_sum_accum;

    localparam int ACC_W = 8;
    localparam int N     = 5;
    localparam int N10   = 10;
    localparam int MAXV  = (1 << ACC_W) - 1;

    typedef struct {
        int acc;
        int ovf;
        int cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_sum = '0;
    logic       in_c_out = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_acc;
    logic       out_overflow;
    logic [2:0] out_count;

    logic       clear10 = 1'b0;
    logic       in_valid10 = 1'b0;
    logic       in_ready10;
    logic [3:0] in_sum10 = '0;
    logic       in_c_out10 = 1'b0;
    logic       out_valid10;
    logic       out_ready10 = 1'b0;
    logic [7:0] out_acc10;
    logic       out_overflow10;
    logic [3:0] out_count10;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    int   frame[$];

    always #5 clk = ~clk;

    adder_sum_accum #(.ACC_W(ACC_W), .N_SAMPLES(N)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_c_out(in_c_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_overflow(out_overflow), .out_count(out_count)
    );

    adder_sum_accum #(.ACC_W(ACC_W), .N_SAMPLES(N10)) dut10 (
        .clk(clk), .rst(rst), .clear(clear10), .in_valid(in_valid10), .in_ready(in_ready10),
        .in_sum(in_sum10), .in_c_out(in_c_out10), .out_valid(out_valid10),
        .out_ready(out_ready10), .out_acc(out_acc10), .out_overflow(out_overflow10),
        .out_count(out_count10)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame total from plain arithmetic: wrap modulo 2^ACC_W, or clamp when saturating.
    function automatic exp_t model(input int total, input int n);
        exp_t e;
        e.ovf = (total > MAXV) ? 1 : 0;
`ifdef ADDER_ACC_SAT_EN
        e.acc = (total > MAXV) ? MAXV : total;
`else
        e.acc = total % (MAXV + 1);
`endif
        e.cnt = n;
        return e;
    endfunction

    // All driving happens 1 time unit after a rising edge.
    task automatic beat(input int v, input int gap);
        int n;
        int total;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        {in_c_out, in_sum} = 5'(v);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        frame.push_back(v);
        if (frame.size() == N) begin
            total = 0;
            foreach (frame[i]) total += frame[i];
            sb.push_back(model(total, N));
            frame.delete();
            check("out_valid_latency", int'(out_valid), 1);
        end else begin
            check("out_valid_early", int'(out_valid), 0);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame: got acc=%0d expected none", out_acc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("frame_acc", int'(out_acc), e.acc);
                check("frame_ovf", int'(out_overflow), e.ovf);
                check("frame_cnt", int'(out_count), e.cnt);
            end
        end
    end

    initial begin
        int total;
        exp_t e;
        repeat (2) cycle();
        rst = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_acc", int'(out_acc), 0);
        check("rst_out_count", int'(out_count), 0);
        check("rst_out_ovf", int'(out_overflow), 0);

        // Five ones, then backpressure with in_valid held high
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) beat(1, 0);
        check("t1_acc", int'(out_acc), 5);
        check("t1_cnt", int'(out_count), 5);
        in_valid = 1'b1;
        {in_c_out, in_sum} = 5'd7;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_acc", int'(out_acc), 5);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        check("post_xfer_in_ready", int'(in_ready), 1);
        check("post_xfer_cnt", int'(out_count), 0);
        check("post_xfer_valid", int'(out_valid), 0);

        // Five beats of 31
        for (int i = 0; i < N; i++) beat(31, 0);
        cycle();
        check("t2_in_ready", int'(in_ready), 1);
        check("t2_cnt", int'(out_count), 0);

        // Clear mid-frame, then a fresh frame of twos
        beat(3, 0);
        beat(3, 0);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        frame.delete();
        check("clr_acc", int'(out_acc), 0);
        check("clr_cnt", int'(out_count), 0);
        for (int i = 0; i < N; i++) beat(2, 0);
        cycle();

        // Clear in DONE discards the result
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) beat(6, 0);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        void'(sb.pop_back());
        check("clr_done_valid", int'(out_valid), 0);
        check("clr_done_acc", int'(out_acc), 0);
        out_ready = 1'b1;

        // Gapped input
        for (int i = 0; i < N; i++) beat(4, (i == 0) ? 0 : 2);
        cycle();

        // Reset mid-frame discards the partial total
        beat(9, 0);
        beat(9, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        frame.delete();
        check("rst_mid_acc", int'(out_acc), 0);
        check("rst_mid_cnt", int'(out_count), 0);

        // Random frames with random gaps and backpressure
        for (int f = 0; f < 20; f++) begin
            out_ready = 1'b0;
            for (int i = 0; i < N; i++) beat(int'($urandom_range(0, 31)), int'($urandom_range(0, 2)));
            repeat ($urandom_range(0, 3)) cycle();
            out_ready = 1'b1;
            cycle();
        end

        // 10-sample instance: all 31 then random values
        for (int f = 0; f < 3; f++) begin
            total = 0;
            for (int i = 0; i < N10; i++) begin
                int v;
                v = (f == 0) ? 31 : int'($urandom_range(0, 31));
                total += v;
                in_valid10 = 1'b1;
                {in_c_out10, in_sum10} = 5'(v);
                cycle();
            end
            in_valid10 = 1'b0;
            e = model(total, N10);
            check("n10_valid", int'(out_valid10), 1);
            check("n10_acc", int'(out_acc10), e.acc);
            check("n10_ovf", int'(out_overflow10), e.ovf);
            check("n10_cnt", int'(out_count10), N10);
            out_ready10 = 1'b1;
            cycle();
            out_ready10 = 1'b0;
            check("n10_in_ready", int'(in_ready10), 1);
            check("n10_ovf_clr", int'(out_overflow10), 0);
        end

        repeat (3) cycle();
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
